// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared limb width, sequencer states and opcode constants
package add_seq_pkg;

  localparam int LIMB_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_seq_cal_slice16.sv
// rtl/add_seq_cal_slice16.sv - combinational 16-bit CLA slice (four 4-bit lookahead groups)
module cal_slice16
  import add_seq_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              ci,
  output logic [LIMB_W-1:0] s,
  output logic              co,
  output logic              c15
);

  logic [LIMB_W-1:0] p;
  logic [LIMB_W-1:0] g;
  logic [3:0]        gp;
  logic [3:0]        gg;
  logic [4:0]        gc;
  logic [LIMB_W:0]   c;
  logic [3:0]        pp;
  logic [3:0]        g4;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    pp = '0;
    g4 = '0;
    for (int i = 0; i < 4; i++) begin
      pp    = p[4*i +: 4];
      g4    = g[4*i +: 4];
      gp[i] = &pp;
      gg[i] = g4[3] | (pp[3] & g4[2]) | (pp[3] & pp[2] & g4[1]) |
              (pp[3] & pp[2] & pp[1] & g4[0]);
    end
    // Second-level lookahead: group carries come straight from ci
    gc[0] = ci;
    gc[1] = gg[0] | (gp[0] & ci);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) |
            (gp[2] & gp[1] & gp[0] & ci);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
            (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
    for (int i = 0; i < 4; i++) begin
      pp         = p[4*i +: 4];
      g4         = g[4*i +: 4];
      c[4*i]     = gc[i];
      c[4*i + 1] = g4[0] | (pp[0] & gc[i]);
      c[4*i + 2] = g4[1] | (pp[1] & g4[0]) | (pp[1] & pp[0] & gc[i]);
      c[4*i + 3] = g4[2] | (pp[2] & g4[1]) | (pp[2] & pp[1] & g4[0]) |
                   (pp[2] & pp[1] & pp[0] & gc[i]);
    end
    c[LIMB_W] = gc[4];
  end

  assign s   = p ^ c[LIMB_W-1:0];
  assign co  = c[LIMB_W];
  assign c15 = c[LIMB_W-1];

endmodule

// File: rtl/add_seq_cal.sv
// rtl/add_seq_cal.sv - multi-precision add/sub sequencer, one 16-bit limb per cycle
// Optional signed-overflow output ovf enabled by ADD_SEQ_CAL_OVF_EN.
module add_seq_cal
  import add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op_sub,
  input  logic                    c_in,
  input  logic [LIMB_W*WORDS-1:0] a,
  input  logic [LIMB_W*WORDS-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LIMB_W*WORDS-1:0] sum,
  output logic                    c_out,
`ifdef ADD_SEQ_CAL_OVF_EN
  output logic                    ovf,
`endif
  output logic                    busy
);

  localparam int W     = LIMB_W * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [LIMB_W-1:0] slice_a;
  logic [LIMB_W-1:0] slice_b;
  logic [LIMB_W-1:0] slice_s;
  logic              slice_co;
  logic              slice_c15;

  assign slice_a = a_q[idx_q*LIMB_W +: LIMB_W];
  assign slice_b = b_q[idx_q*LIMB_W +: LIMB_W];

  cal_slice16 u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .ci  (carry_q),
    .s   (slice_s),
    .co  (slice_co),
    .c15 (slice_c15)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // Subtract is folded into the operands: ~B here, forced carry below
          b_d     = (op_sub == OP_SUB) ? ~b : b;
          carry_d = (op_sub == OP_SUB) ? 1'b1 : c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*LIMB_W +: LIMB_W] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(WORDS - 1)) begin
          c_out_d = slice_co;
          ovf_d   = slice_co ^ slice_c15;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

`ifdef ADD_SEQ_CAL_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q ^ slice_c15;
`endif

endmodule
